// File: rtl/seg_scan_decoder.sv
// Readback decoder for a multiplexed 7-segment display: captures each scanned glyph and publishes 8-digit frames.
// Optional binary pair outputs (bin0/bin1/bin2) are built only when SEG_BIN_OUT_EN is defined.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sel,
  input  logic [6:0]  data,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        sel_err,
  output logic        stalled
`ifdef SEG_BIN_OUT_EN
  ,
  output logic [6:0]  bin0,
  output logic [6:0]  bin1,
  output logic [6:0]  bin2
`endif
);

  localparam int unsigned NPOS = 8;
  localparam int unsigned SEGW = 7;
  localparam int unsigned CW   = 8;
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES);

  logic [NPOS-1:0] sel_n;
  logic [SEGW-1:0] seg_n;
  logic            sel_none;
  logic            sel_multi;
  logic            sel_valid;
  logic [2:0]      pos;
  logic            same;
  logic [3:0]      glyph_dig;
  logic            glyph_bad;
  logic            capture;
  logic            frame_done;

  logic [NPOS-1:0] prev_sel_q;
  logic [SEGW-1:0] prev_seg_q;
  logic [CW-1:0]   stab_q, stab_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [NPOS-1:0] mask_q, mask_d;
  logic [TW-1:0]   to_q, to_d;

  // Glyph (active-high gfedcba) to digit; blank is 0xF, anything unknown is 0xE.
  function automatic logic [3:0] decode(input logic [6:0] g);
    case (g)
      7'h3F:   decode = 4'h0;
      7'h06:   decode = 4'h1;
      7'h5B:   decode = 4'h2;
      7'h4F:   decode = 4'h3;
      7'h66:   decode = 4'h4;
      7'h6D:   decode = 4'h5;
      7'h7D:   decode = 4'h6;
      7'h07:   decode = 4'h7;
      7'h7F:   decode = 4'h8;
      7'h6F:   decode = 4'h9;
      7'h00:   decode = 4'hF;
      default: decode = 4'hE;
    endcase
  endfunction

`ifdef SEG_BIN_OUT_EN
  function automatic logic [6:0] pair_bin(input logic [3:0] tens, input logic [3:0] ones);
    if (tens > 4'd9 || ones > 4'd9) begin
      return 7'd127;
    end
    return 7'({3'b000, tens} * 7'd10 + {3'b000, ones});
  endfunction
`endif

  // Normalise polarity and classify the select lines.
  always_comb begin
    sel_n     = SEL_ACTIVE_LOW ? ~sel : sel;
    seg_n     = SEG_ACTIVE_LOW ? ~data : data;
    sel_none  = (sel_n == '0);
    sel_multi = ((sel_n & (sel_n - 8'd1)) != '0);
    sel_valid = !sel_none && !sel_multi;
    pos       = 3'd0;
    for (int i = 0; i < NPOS; i++) begin
      if (sel_n[i]) pos = 3'(i);
    end
    same      = (sel_n == prev_sel_q) && (seg_n == prev_seg_q);
    glyph_dig = decode(seg_n);
    glyph_bad = (glyph_dig == 4'hE);
  end

  // Stability counting; capture fires once per dwell when the count first hits STABLE_MAX.
  always_comb begin
    stab_d  = '0;
    capture = 1'b0;
    if (sel_valid) begin
      if (!same) begin
        stab_d = CW'(1);
      end else if (stab_q < STABLE_MAX) begin
        stab_d = stab_q + CW'(1);
      end else begin
        stab_d = stab_q;
      end
      capture = (stab_d == STABLE_MAX) && (!same || stab_q != STABLE_MAX);
    end
  end

  // Shadow/mask update and timeout count.
  always_comb begin
    shadow_d = shadow_q;
    mask_d   = mask_q;
    if (capture) begin
      shadow_d[{pos, 2'b00} +: 4] = glyph_dig;
      mask_d[pos]                 = 1'b1;
    end
    frame_done = (mask_d == '1);
    if (capture) begin
      to_d = '0;
    end else if (to_q == TO_MAX) begin
      to_d = to_q;
    end else begin
      to_d = to_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sel_q  <= '0;
      prev_seg_q  <= '0;
      stab_q      <= '0;
      shadow_q    <= '0;
      mask_q      <= '0;
      to_q        <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      sel_err     <= 1'b0;
      stalled     <= 1'b0;
`ifdef SEG_BIN_OUT_EN
      bin0        <= '0;
      bin1        <= '0;
      bin2        <= '0;
`endif
    end else begin
      prev_sel_q  <= sel_n;
      prev_seg_q  <= seg_n;
      stab_q      <= stab_d;
      shadow_q    <= shadow_d;
      mask_q      <= frame_done ? '0 : mask_d;
      to_q        <= to_d;
      frame_valid <= frame_done;
      // A new error event outranks a simultaneous clear.
      seg_err     <= (capture && glyph_bad) || (seg_err && !err_clr);
      sel_err     <= sel_multi || (sel_err && !err_clr);
      stalled     <= (to_d == TO_MAX);
      if (frame_done) begin
        digits <= shadow_d;
`ifdef SEG_BIN_OUT_EN
        bin0   <= pair_bin(shadow_d[7:4],   shadow_d[3:0]);
        bin1   <= pair_bin(shadow_d[15:12], shadow_d[11:8]);
        bin2   <= pair_bin(shadow_d[23:20], shadow_d[19:16]);
`endif
      end
    end
  end

endmodule
